// File: rtl/ftoi_pipe.sv
// Pipelined binary32 -> signed integer converter with selectable rounding, saturation and inexact flag.
// Valid/ready on both ports; a single advance enable moves every stage, bubbles included.
module ftoi_pipe #(
  parameter int OUT_W  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [1:0]       rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             ovf,
  output logic             nx,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic        s;
    logic [1:0]  rm;
    logic        zero;
    logic        nan;
    logic        big;
    logic [31:0] mag;
    logic        g;
    logic        st;
  } unp_t;

  typedef struct packed {
    logic [OUT_W-1:0] y;
    logic             ovf;
    logic             nx;
  } res_t;

  // Right shifts are clamped at 63: anything further only feeds sticky, which is already set.
  function automatic unp_t unpack(input logic [31:0] v, input logic [1:0] r);
    unp_t        u;
    logic [7:0]  e;
    logic [7:0]  sh;
    logic [63:0] ext;
    e      = v[30:23];
    u.s    = v[31];
    u.rm   = r;
    u.zero = (e == 8'd0);
    u.nan  = (e == 8'hFF) && (v[22:0] != 23'd0);
    u.big  = (e >= 8'(127 + OUT_W - 1));
    u.mag  = '0;
    u.g    = 1'b0;
    u.st   = 1'b0;
    if (e >= 8'd150) begin
      sh    = e - 8'd150;
      u.mag = {8'd0, 1'b1, v[22:0]} << sh[2:0];
    end else begin
      sh    = 8'd150 - e;
      ext   = {1'b1, v[22:0], 40'd0} >> ((sh > 8'd63) ? 6'd63 : sh[5:0]);
      u.mag = {8'd0, ext[63:40]};
      u.g   = ext[39];
      u.st  = |ext[38:0];
    end
    return u;
  endfunction

  function automatic res_t round_pack(input unp_t u);
    res_t        o;
    logic        inc;
    logic        lost;
    logic [32:0] mr;
    lost = u.g | u.st;
    case (u.rm)
      2'b00:   inc = u.g;
      2'b01:   inc = 1'b0;
      2'b10:   inc = u.s & lost;
      default: inc = ~u.s & lost;
    endcase
    mr    = {1'b0, u.mag} + {32'd0, inc};
    o.ovf = u.big || (mr >= (33'd1 << (OUT_W - 1)));
    o.nx  = lost & ~o.ovf;
    o.y   = u.s ? -mr[OUT_W-1:0] : mr[OUT_W-1:0];
    if (o.ovf) o.y = (u.nan || !u.s) ? MAXV : MINV;
    if (u.zero) o = '0;
    return o;
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][TAG_W-1:0] tag_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      tag_pipe[1] <= in_tag;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  unp_t ua_c, ua;
  res_t rb_c, rb;
  assign ua_c = unpack(x, rm);

  generate
    if (STAGES >= 2) begin : g_reg_a
      always_ff @(posedge clk) begin
        if (rst)     ua <= '0;
        else if (en) ua <= ua_c;
      end
    end else begin : g_pass_a
      assign ua = ua_c;
    end
  endgenerate

  assign rb_c = round_pack(ua);

  generate
    if (STAGES >= 3) begin : g_reg_b
      always_ff @(posedge clk) begin
        if (rst)     rb <= '0;
        else if (en) rb <= rb_c;
      end
    end else begin : g_pass_b
      assign rb = rb_c;
    end
  endgenerate

  // Output register holds whenever the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      y   <= '0;
      ovf <= 1'b0;
      nx  <= 1'b0;
    end else if (en) begin
      y   <= rb.y;
      ovf <= rb.ovf;
      nx  <= rb.nx;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_tag   = tag_pipe[STAGES];

endmodule
